timer_countdown: RTL and testbench
==================================

Name: timer_countdown

Overview:
- Consumer end of the keypad timer-entry interface. Takes BCD digits qualified by the active-low LOAD_N strobe, plus the 1 Hz tick from the keypad/clock-divider block.
- Builds an M:SS cook time by shifting digits in, then counts it down once per second.
- Flags completion to the microwave controller (magnetron/lamp/beeper logic).
- Single clock domain (CLK_100HZ).

Parameters:
- DONE_CYCLES, 300, CLK_100HZ cycles spent in DONE before auto-return to IDLE (3 s).

Ports:
- CLK_100HZ  input  1  system clock, 100 Hz; all logic on rising edge
- RST_N  input  1  asynchronous active-low reset
- D  input  4  BCD digit from keypad encoder; valid while LOAD_N=0
- LOAD_N  input  1  active-low digit strobe; one digit accepted per falling edge
- CLK_1HZ  input  1  1 Hz tick level; each rising edge is one countdown step
- START_N  input  1  active-low start request (level, edge-detected)
- STOP_N  input  1  active-low stop/clear request (level, edge-detected)
- MIN_ONES  output  4  minutes digit, BCD 0-9
- SEC_TENS  output  4  seconds tens digit, BCD 0-5
- SEC_ONES  output  4  seconds ones digit, BCD 0-9
- RUNNING  output  1  high in RUN
- DONE  output  1  high in DONE
- ZERO  output  1  high when all three digits are 0 (combinational from registers)

Behaviour:
- Clock and reset: one clock, CLK_100HZ. RST_N is asynchronous, active-low.
- All inputs are synchronous to CLK_100HZ; no synchronizers.
- Edge detection: one register each holds the previous LOAD_N, CLK_1HZ, START_N and STOP_N. An event is registered at the first rising edge where the current sample is active and the previous sample was inactive (for example, CLK_1HZ=1 and prev=0). State and digit updates take effect at that same edge.
- Reset values: digits 0, state IDLE, RUNNING=0, DONE=0, ZERO=1, edge registers inactive (LOAD_N/START_N/STOP_N prev=1, CLK_1HZ prev=0).
- Reset asserted mid-count aborts immediately to the reset values.
- States: IDLE, RUN, DONE.
- IDLE, load event:
  - If D<=9: shift MIN_ONES<=SEC_TENS, SEC_TENS<=SEC_ONES, SEC_ONES<=D.
  - If D>9: ignore the event.
  - The digit that falls off the MIN_ONES end is discarded.
  - Shift-in does not validate SEC_TENS<=5; a value of 6-9 is clamped to 5 at the start event.
- IDLE, start event with ZERO=0 -> RUN. Start with ZERO=1 is ignored.
- IDLE, stop event: clear all digits.
- RUN, tick event: BCD decrement of M:SS.
  - SEC_ONES 0 -> 9 with borrow.
  - SEC_TENS 0 -> 5 with borrow.
  - MIN_ONES decrements on borrow.
  - If the result is 0:00 -> DONE at the same edge.
- RUN: load events are ignored.
- DONE:
  - Digits hold at 0 and DONE=1.
  - A cycle counter runs from 0 to DONE_CYCLES-1, then the state returns to IDLE.
  - Any start, stop or load event in DONE -> IDLE immediately. That event has no other effect.
- Simultaneous events, priority stop > start > tick > load:
  - Stop and tick in the same cycle in RUN: stop wins, no decrement.
  - Start and load in the same cycle in IDLE: start wins, the digit is dropped.
- Ticks outside RUN are ignored. The tick edge register still updates every cycle, so no stale edge fires on entry to RUN.

Optional Feature:
- Macro TIMER_PAUSE_EN.
- Defined: adds state PAUSE.
  - Stop event in RUN -> PAUSE; digits are preserved, RUNNING=0.
  - Start event in PAUSE -> RUN.
  - Stop event in PAUSE -> IDLE with digits cleared.
  - Loads and ticks are ignored in PAUSE.
- Undefined: stop event in RUN -> IDLE with digits cleared. The PAUSE encoding is absent.

Decomposition:
- Shared package timer_pkg holds:
  - state typedef (IDLE, RUN, DONE, PAUSE under the macro)
  - BCD_MAX_ONES=9 and BCD_MAX_TENS=5
  - DONE_CYCLES default
- One sub-module, bcd_digit_dec:
  - one BCD digit with parameterised max, decrement enable and borrow out
  - instantiated three times in a ripple chain.

Test Plan:
- Reset then loads D=1,3,0 -> digits 1:30, ZERO=0; then load D=12 -> ignored, still 1:30.
- Start at 0:02, then two CLK_1HZ rising edges -> 0:01, then 0:00, with DONE=1 and RUNNING=0 at the second tick edge; DONE clears after 300 cycles.
- Start at 1:00, one tick -> 0:59 (borrow chain). Start with 0:70 loaded -> clamped to 0:50 before counting.
- Stop and tick in the same cycle in RUN at 0:45 -> no decrement. Without the macro: IDLE, 0:00. With TIMER_PAUSE_EN: PAUSE, 0:45; start -> RUN, next tick -> 0:44.
- Start with 0:00 in IDLE -> stays IDLE, RUNNING=0. RST_N pulsed low mid-RUN at 0:30 -> asynchronous return to IDLE, 0:00, ZERO=1.
- Load event in DONE -> IDLE immediately, digits 0:00 (the digit is not shifted in).

Source files
------------

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the keypad countdown timer.
//   state_t / ST_*     : controller state encodings (ST_PAUSE only exists when
//                        TIMER_PAUSE_EN is defined)
//   BCD_MAX_ONES/TENS  : roll-over values for ones and tens digits
//   DONE_CYCLES_DEFAULT: clock cycles spent showing DONE before returning idle
// Optional feature macro: TIMER_PAUSE_EN
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DONE  = 2'd2;
`ifdef TIMER_PAUSE_EN
    localparam state_t ST_PAUSE = 2'd3;
`endif

    localparam logic [3:0] BCD_MAX_ONES = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;

    localparam int DONE_CYCLES_DEFAULT = 300;

    // True when a keypad code is a legal decimal digit.
    function automatic logic is_bcd(input logic [3:0] value);
        return value <= BCD_MAX_ONES;
    endfunction

    // Seconds tens are shifted in unchecked; anything above 5 becomes 5.
    function automatic logic [3:0] clamp_tens(input logic [3:0] value);
        return (value > BCD_MAX_TENS) ? BCD_MAX_TENS : value;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// -----------------------------------------------------------------------------
// bcd_digit_dec
// Combinational decrement of one BCD digit with a configurable roll-over value.
// Chained ones -> tens -> minutes, each stage's borrow enabling the next.
//   MAX        : value the digit wraps to when decremented from 0
//   digit      : current digit value
//   dec        : decrement request (borrow in)
//   digit_next : decremented value (equals digit when dec=0)
//   borrow     : high when this digit wrapped and the next digit must decrement
// -----------------------------------------------------------------------------
module bcd_digit_dec
    import timer_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX_ONES
) (
    input  logic [3:0] digit,
    input  logic       dec,
    output logic [3:0] digit_next,
    output logic       borrow
);

    always_comb begin
        borrow     = dec && (digit == 4'd0);
        digit_next = digit;
        if (dec) begin
            digit_next = (digit == 4'd0) ? MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/timer_countdown.sv
// -----------------------------------------------------------------------------
// timer_countdown
// Keypad-fed M:SS countdown timer for the microwave controller.
// Digits are shifted in on LOAD_N strobes, START_N begins a once-per-second
// countdown driven by CLK_1HZ, and DONE is flagged for DONE_CYCLES clocks
// when the count reaches 0:00.
//   CLK_100HZ : system clock, rising edge
//   RST_N     : asynchronous active-low reset
//   D         : BCD digit, sampled on a LOAD_N falling edge
//   LOAD_N    : active-low digit strobe
//   CLK_1HZ   : 1 Hz tick level, each rising edge is one countdown step
//   START_N   : active-low start request
//   STOP_N    : active-low stop/clear request
//   MIN_ONES, SEC_TENS, SEC_ONES : displayed M:SS digits
//   RUNNING   : counting down
//   DONE      : countdown finished
//   ZERO      : all digits are zero
// Optional feature macro: TIMER_PAUSE_EN (stop in RUN pauses instead of
// clearing; a second stop clears).
// -----------------------------------------------------------------------------
module timer_countdown
    import timer_pkg::*;
#(
    parameter int DONE_CYCLES = DONE_CYCLES_DEFAULT
) (
    input  logic       CLK_100HZ,
    input  logic       RST_N,
    input  logic [3:0] D,
    input  logic       LOAD_N,
    input  logic       CLK_1HZ,
    input  logic       START_N,
    input  logic       STOP_N,
    output logic [3:0] MIN_ONES,
    output logic [3:0] SEC_TENS,
    output logic [3:0] SEC_ONES,
    output logic       RUNNING,
    output logic       DONE,
    output logic       ZERO
);

    localparam int              CNT_W    = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_CYCLES - 1);

    state_t           state;
    logic [3:0]       min_ones;
    logic [3:0]       sec_tens;
    logic [3:0]       sec_ones;
    logic [CNT_W-1:0] done_cnt;

    logic load_prev;
    logic tick_prev;
    logic start_prev;
    logic stop_prev;

    logic load_ev;
    logic tick_ev;
    logic start_ev;
    logic stop_ev;

    logic [3:0] ones_dec;
    logic [3:0] tens_dec;
    logic [3:0] min_dec;
    logic       ones_borrow;
    logic       tens_borrow;
    logic       min_borrow;
    logic       dec_is_zero;

    // An event is the first cycle an input is seen active after being inactive.
    always_comb begin
        load_ev  = !LOAD_N  &&  load_prev;
        tick_ev  =  CLK_1HZ && !tick_prev;
        start_ev = !START_N &&  start_prev;
        stop_ev  = !STOP_N  &&  stop_prev;
    end

    // Ripple borrow chain: ones always decrement on a tick, higher digits
    // only when the digit below wrapped.
    bcd_digit_dec #(.MAX(BCD_MAX_ONES)) u_sec_ones (
        .digit      (sec_ones),
        .dec        (1'b1),
        .digit_next (ones_dec),
        .borrow     (ones_borrow)
    );

    bcd_digit_dec #(.MAX(BCD_MAX_TENS)) u_sec_tens (
        .digit      (sec_tens),
        .dec        (ones_borrow),
        .digit_next (tens_dec),
        .borrow     (tens_borrow)
    );

    bcd_digit_dec #(.MAX(BCD_MAX_ONES)) u_min_ones (
        .digit      (min_ones),
        .dec        (tens_borrow),
        .digit_next (min_dec),
        .borrow     (min_borrow)
    );

    // RUN never holds 0:00, so a borrow out of the minutes digit cannot
    // coincide with a zero result; it is folded in only to keep the test exact.
    always_comb begin
        dec_is_zero = (min_dec == 4'd0) && (tens_dec == 4'd0) &&
                      (ones_dec == 4'd0) && !min_borrow;
    end

    // Main controller. Within a state, events are resolved in the order
    // stop, start, tick, load, so the lower-priority event in a collision
    // is simply dropped.
    always_ff @(posedge CLK_100HZ or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            done_cnt   <= '0;
            load_prev  <= 1'b1;
            tick_prev  <= 1'b0;
            start_prev <= 1'b1;
            stop_prev  <= 1'b1;
        end else begin
            load_prev  <= LOAD_N;
            tick_prev  <= CLK_1HZ;
            start_prev <= START_N;
            stop_prev  <= STOP_N;

            case (state)
                ST_IDLE: begin
                    if (stop_ev) begin
                        min_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        sec_ones <= 4'd0;
                    end else if (start_ev) begin
                        if (!ZERO) begin
                            state    <= ST_RUN;
                            sec_tens <= clamp_tens(sec_tens);
                        end
                    end else if (load_ev && is_bcd(D)) begin
                        min_ones <= sec_tens;
                        sec_tens <= sec_ones;
                        sec_ones <= D;
                    end
                end

                ST_RUN: begin
                    if (stop_ev) begin
`ifdef TIMER_PAUSE_EN
                        state <= ST_PAUSE;
`else
                        state    <= ST_IDLE;
                        min_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        sec_ones <= 4'd0;
`endif
                    end else if (tick_ev) begin
                        min_ones <= min_dec;
                        sec_tens <= tens_dec;
                        sec_ones <= ones_dec;
                        if (dec_is_zero) begin
                            state    <= ST_DONE;
                            done_cnt <= '0;
                        end
                    end
                end

                ST_DONE: begin
                    // Any keypad activity acknowledges completion and does
                    // nothing else; otherwise time out after DONE_CYCLES.
                    if (start_ev || stop_ev || load_ev) begin
                        state <= ST_IDLE;
                    end else if (done_cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        done_cnt <= done_cnt + CNT_W'(1);
                    end
                end

`ifdef TIMER_PAUSE_EN
                ST_PAUSE: begin
                    if (stop_ev) begin
                        state    <= ST_IDLE;
                        min_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        sec_ones <= 4'd0;
                    end else if (start_ev) begin
                        state <= ST_RUN;
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and display outputs straight from the registers.
    always_comb begin
        MIN_ONES = min_ones;
        SEC_TENS = sec_tens;
        SEC_ONES = sec_ones;
        RUNNING  = (state == ST_RUN);
        DONE     = (state == ST_DONE);
        ZERO     = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    end

endmodule

// File: tb/tb_timer_countdown.sv
// -----------------------------------------------------------------------------
// tb_timer_countdown
// Self-checking bench for timer_countdown. A driver issues one input vector
// per clock and pushes the expected outputs from a time-in-seconds reference
// model into a queue; a monitor pops and compares after every rising edge.
// Directed scenarios add fixed-value checks; a randomized phase follows.
// Honors TIMER_PAUSE_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_timer_countdown;

    localparam int DONE_CYCLES = 300;

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic       run;
        logic       done;
        logic       zero;
    } out_t;

    typedef enum {M_IDLE, M_RUN, M_DONE, M_PAUSE} mstate_e;

    logic       clk_100hz = 1'b0;
    logic       rst_n;
    logic [3:0] d;
    logic       load_n;
    logic       clk_1hz;
    logic       start_n;
    logic       stop_n;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;
    logic       zero;

    int n_checks = 0;
    int n_fail   = 0;

    out_t expq[$];

    // Reference model: digits while idle, total seconds while counting.
    mstate_e m_state;
    int      m_dig[3];
    int      m_secs;
    int      m_dcnt;
    bit      m_pl, m_pt, m_ps, m_pp;
    bit      c1_level;

    timer_countdown #(.DONE_CYCLES(DONE_CYCLES)) dut (
        .CLK_100HZ (clk_100hz),
        .RST_N     (rst_n),
        .D         (d),
        .LOAD_N    (load_n),
        .CLK_1HZ   (clk_1hz),
        .START_N   (start_n),
        .STOP_N    (stop_n),
        .MIN_ONES  (min_ones),
        .SEC_TENS  (sec_tens),
        .SEC_ONES  (sec_ones),
        .RUNNING   (running),
        .DONE      (done),
        .ZERO      (zero)
    );

    always #5 clk_100hz = ~clk_100hz;

    function automatic out_t mk(input int m, input int t, input int o,
                                input bit run, input bit dn);
        out_t r;
        r.m    = 4'(m);
        r.t    = 4'(t);
        r.o    = 4'(o);
        r.run  = run;
        r.done = dn;
        r.zero = (m == 0) && (t == 0) && (o == 0);
        return r;
    endfunction

    function automatic out_t model_out();
        return mk(m_dig[0], m_dig[1], m_dig[2], m_state == M_RUN, m_state == M_DONE);
    endfunction

    task automatic modelReset();
        m_state = M_IDLE;
        m_dig   = '{0, 0, 0};
        m_secs  = 0;
        m_dcnt  = 0;
        m_pl    = 1'b1;
        m_pt    = 1'b0;
        m_ps    = 1'b1;
        m_pp    = 1'b1;
    endtask

    task automatic setFromSecs();
        m_dig[0] = m_secs / 60;
        m_dig[1] = (m_secs % 60) / 10;
        m_dig[2] = m_secs % 10;
    endtask

    task automatic modelClear();
        m_dig  = '{0, 0, 0};
        m_secs = 0;
    endtask

    // One clock of the reference behaviour for the given input levels.
    task automatic modelStep(input bit ln, input int dv, input bit c1,
                             input bit sn, input bit pn);
        bit load_e, tick_e, start_e, stop_e;
        load_e  = !ln && m_pl;
        tick_e  =  c1 && !m_pt;
        start_e = !sn && m_ps;
        stop_e  = !pn && m_pp;
        m_pl = ln; m_pt = c1; m_ps = sn; m_pp = pn;
        case (m_state)
            M_IDLE: begin
                if (stop_e) begin
                    modelClear();
                end else if (start_e) begin
                    m_secs = m_dig[0] * 60 + ((m_dig[1] > 5) ? 5 : m_dig[1]) * 10 + m_dig[2];
                    if (m_secs != 0) begin
                        m_state = M_RUN;
                        setFromSecs();
                    end
                end else if (load_e && dv <= 9) begin
                    m_dig[0] = m_dig[1];
                    m_dig[1] = m_dig[2];
                    m_dig[2] = dv;
                end
            end
            M_RUN: begin
                if (stop_e) begin
`ifdef TIMER_PAUSE_EN
                    m_state = M_PAUSE;
`else
                    m_state = M_IDLE;
                    modelClear();
`endif
                end else if (tick_e) begin
                    m_secs = m_secs - 1;
                    setFromSecs();
                    if (m_secs == 0) begin
                        m_state = M_DONE;
                        m_dcnt  = 0;
                    end
                end
            end
            M_DONE: begin
                if (start_e || stop_e || load_e) m_state = M_IDLE;
                else if (m_dcnt == DONE_CYCLES - 1) m_state = M_IDLE;
                else m_dcnt++;
            end
            M_PAUSE: begin
                if (stop_e) begin
                    m_state = M_IDLE;
                    modelClear();
                end else if (start_e) begin
                    m_state = M_RUN;
                end
            end
            default: m_state = M_IDLE;
        endcase
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = '{min_ones, sec_tens, sec_ones, running, done, zero};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s @%0t: got %0h:%0h%0h run=%b done=%b zero=%b, expected %0h:%0h%0h run=%b done=%b zero=%b",
                     name, $time, act.m, act.t, act.o, act.run, act.done, act.zero,
                     exp.m, exp.t, exp.o, exp.run, exp.done, exp.zero);
        end
    endtask

    // Drive one clock's worth of inputs and queue the expected result.
    task automatic applyStimulus(input bit ln, input logic [3:0] dv, input bit c1,
                                 input bit sn, input bit pn);
        @(negedge clk_100hz);
        load_n  = ln;
        d       = dv;
        clk_1hz = c1;
        start_n = sn;
        stop_n  = pn;
        c1_level = c1;
        modelStep(ln, int'(dv), c1, sn, pn);
        expq.push_back(model_out());
    endtask

    task automatic checkNow(input string name, input out_t exp);
        @(posedge clk_100hz);
        #2;
        checkOutput(name, exp);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic pressDigit(input logic [3:0] dv);
        applyStimulus(1'b0, dv, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, dv, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic pressStart();
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        idleCycle();
    endtask

    task automatic pressStop();
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        idleCycle();
    endtask

    task automatic tick();
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
        idleCycle();
    endtask

    // Two stops leave the timer idle and cleared from any state.
    task automatic clearAll();
        pressStop();
        pressStop();
    endtask

    // Reset asserted between clock edges must act without waiting for one.
    task automatic resetPulse();
        @(negedge clk_100hz);
        load_n   = 1'b1;
        clk_1hz  = 1'b0;
        start_n  = 1'b1;
        stop_n   = 1'b1;
        c1_level = 1'b0;
        rst_n    = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset", mk(0, 0, 0, 0, 0));
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every queued expectation one step after its clock edge.
    initial begin
        out_t exp_o;
        forever begin
            @(posedge clk_100hz);
            #1;
            if (expq.size() > 0) begin
                exp_o = expq.pop_front();
                checkOutput("scoreboard", exp_o);
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        rst_n    = 1'b0;
        d        = 4'd0;
        load_n   = 1'b1;
        clk_1hz  = 1'b0;
        start_n  = 1'b1;
        stop_n   = 1'b1;
        c1_level = 1'b0;
        modelReset();
        repeat (2) @(posedge clk_100hz);
        #1;
        checkOutput("reset_state", mk(0, 0, 0, 0, 0));
        @(negedge clk_100hz);
        rst_n = 1'b1;

        $display("[TB] digit entry");
        pressDigit(4'd1); pressDigit(4'd3); pressDigit(4'd0);
        checkNow("load_130", mk(1, 3, 0, 0, 0));
        pressDigit(4'd12);
        checkNow("load_invalid", mk(1, 3, 0, 0, 0));

        $display("[TB] countdown to done and timeout");
        clearAll();
        pressDigit(4'd0); pressDigit(4'd2);
        pressStart();
        checkNow("start_002", mk(0, 0, 2, 1, 0));
        tick();
        checkNow("tick_001", mk(0, 0, 1, 1, 0));
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
        checkNow("tick_done", mk(0, 0, 0, 0, 1));
        idleCycle();
        repeat (DONE_CYCLES - 2) idleCycle();
        checkNow("done_hold", mk(0, 0, 0, 0, 1));
        idleCycle();
        checkNow("done_expire", mk(0, 0, 0, 0, 0));

        $display("[TB] borrow chain and clamp");
        pressDigit(4'd1); pressDigit(4'd0); pressDigit(4'd0);
        pressStart();
        tick();
        checkNow("borrow_059", mk(0, 5, 9, 1, 0));
        clearAll();
        pressDigit(4'd0); pressDigit(4'd7); pressDigit(4'd0);
        checkNow("load_070", mk(0, 7, 0, 0, 0));
        pressStart();
        checkNow("clamp_050", mk(0, 5, 0, 1, 0));
        clearAll();

        $display("[TB] stop and tick together");
        pressDigit(4'd0); pressDigit(4'd4); pressDigit(4'd5);
        pressStart();
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
        idleCycle();
`ifdef TIMER_PAUSE_EN
        checkNow("stop_tick_pause", mk(0, 4, 5, 0, 0));
        pressStart();
        checkNow("resume", mk(0, 4, 5, 1, 0));
        tick();
        checkNow("resume_tick", mk(0, 4, 4, 1, 0));
`else
        checkNow("stop_tick_clear", mk(0, 0, 0, 0, 0));
`endif
        clearAll();

        $display("[TB] start at zero, reset mid-run, load in done");
        pressStart();
        checkNow("start_zero", mk(0, 0, 0, 0, 0));
        pressDigit(4'd0); pressDigit(4'd3); pressDigit(4'd0);
        pressStart();
        checkNow("run_030", mk(0, 3, 0, 1, 0));
        resetPulse();
        checkNow("post_reset", mk(0, 0, 0, 0, 0));
        pressDigit(4'd0); pressDigit(4'd0); pressDigit(4'd1);
        pressStart();
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
        checkNow("done_001", mk(0, 0, 0, 0, 1));
        pressDigit(4'd7);
        checkNow("load_in_done", mk(0, 0, 0, 0, 0));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 4000; i++) begin
            bit         ln, sn, pn;
            logic [3:0] dv;
            if ($urandom_range(0, 599) == 0) begin
                resetPulse();
            end else begin
                ln = ($urandom_range(0, 7) != 0);
                dv = 4'($urandom_range(0, 15));
                sn = ($urandom_range(0, 19) != 0);
                pn = ($urandom_range(0, 59) != 0);
                if ($urandom_range(0, 3) == 0) c1_level = ~c1_level;
                applyStimulus(ln, dv, c1_level, sn, pn);
            end
        end

        @(posedge clk_100hz);
        #3;
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
